// File: rtl/reg_bank_shadow_if.sv
// Write/commit/readback bundle for reg_bank_shadow; the master drives requests, the slave is the bank.
interface reg_bank_shadow_if #(
    parameter int unsigned NCH = 3,
    parameter int unsigned DW  = 8,
    parameter int unsigned AW  = 2
) ();
    logic                wr_valid;
    logic                wr_ready;
    logic [AW-1:0]       wr_addr;
    logic [DW-1:0]       wr_data;
    logic                commit;
    logic                busy;
    logic                updated;
    logic [NCH-1:0]      pending;
    logic                err;
    logic [NCH*DW-1:0]   dout;
    logic [AW-1:0]       rd_addr;
    logic [DW-1:0]       rd_data;

    modport master (
        output wr_valid, wr_addr, wr_data, commit, rd_addr,
        input  wr_ready, busy, updated, pending, err, dout, rd_data
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, commit, rd_addr,
        output wr_ready, busy, updated, pending, err, dout, rd_data
    );
endinterface

// File: rtl/reg_bank_shadow.sv
// N-channel shadowed register bank with atomic commit of all pending shadows.
// Optional registered readback port is built when REG_BANK_READBACK_EN is defined.
module reg_bank_shadow #(
    parameter int unsigned   NCH  = 3,
    parameter int unsigned   DW   = 8,
    parameter int unsigned   AW   = 2,
    parameter logic [DW-1:0] RSTV = '0
) (
    input logic              clk,
    input logic              rst,
    reg_bank_shadow_if.slave bus
);

    typedef enum logic [0:0] {StIdle, StCmt} state_e;

    state_e         state_q, state_d;
    logic [DW-1:0]  shadow_q [NCH];
    logic [DW-1:0]  shadow_d [NCH];
    logic [DW-1:0]  active_q [NCH];
    logic [DW-1:0]  active_d [NCH];
    logic [NCH-1:0] pending_q, pending_d;
    logic           err_q, err_d;
    logic           updated_q, updated_d;
    logic           wr_ready, busy, wr_fire;

    always_comb begin
        state_d  = state_q;
        wr_ready = 1'b0;
        busy     = 1'b0;
        unique case (state_q)
            StIdle: begin
                wr_ready = 1'b1;
                if (bus.commit) state_d = StCmt;
            end
            StCmt: begin
                busy    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign wr_fire = bus.wr_valid & wr_ready;

    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        err_d     = err_q;
        updated_d = 1'b0;
        if (wr_fire) begin
            // Out-of-range writes are still handshaken so the master never stalls on them
            if (32'(bus.wr_addr) >= NCH) err_d = 1'b1;
            for (int unsigned i = 0; i < NCH; i++) begin
                if (32'(bus.wr_addr) == i) begin
                    shadow_d[i]  = bus.wr_data;
                    pending_d[i] = 1'b1;
                end
            end
        end
        if (state_q == StCmt) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                if (pending_q[i]) active_d[i] = shadow_q[i];
            end
            pending_d = '0;
            updated_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            pending_q <= '0;
            err_q     <= 1'b0;
            updated_q <= 1'b0;
            for (int unsigned i = 0; i < NCH; i++) begin
                shadow_q[i] <= RSTV;
                active_q[i] <= RSTV;
            end
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            err_q     <= err_d;
            updated_q <= updated_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
        end
    end

    assign bus.wr_ready = wr_ready;
    assign bus.busy     = busy;
    assign bus.updated  = updated_q;
    assign bus.pending  = pending_q;
    assign bus.err      = err_q;

    for (genvar g = 0; g < NCH; g++) begin : g_dout
        assign bus.dout[g*DW +: DW] = active_q[g];
    end

`ifdef REG_BANK_READBACK_EN
    logic [DW-1:0] rd_data_q, rd_data_d;

    always_comb begin
        rd_data_d = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (32'(bus.rd_addr) == i) rd_data_d = active_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) rd_data_q <= '0;
        else     rd_data_q <= rd_data_d;
    end

    assign bus.rd_data = rd_data_q;
`else
    logic unused_rd_addr;
    assign unused_rd_addr = ^bus.rd_addr;
    assign bus.rd_data    = '0;
`endif

endmodule

// File: tb/tb_reg_bank_shadow.sv
// Directed plus randomized bench for reg_bank_shadow against a cycle-level bank model.
module tb_reg_bank_shadow;
    localparam int unsigned   NCH  = 3;
    localparam int unsigned   DW   = 8;
    localparam int unsigned   AW   = 2;
    localparam logic [DW-1:0] RSTV = 8'h00;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reg_bank_shadow_if #(.NCH(NCH), .DW(DW), .AW(AW)) bus ();

    reg_bank_shadow #(.NCH(NCH), .DW(DW), .AW(AW), .RSTV(RSTV)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;

    // Model: shadow/active contents, pending mask, sticky error, commit-in-flight flag
    logic [DW-1:0]  m_sh  [NCH];
    logic [DW-1:0]  m_act [NCH];
    logic [NCH-1:0] m_pend;
    bit             m_err, m_cmt, m_upd;
    logic [DW-1:0]  m_rd;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NCH*DW-1:0] model_dout();
        logic [NCH*DW-1:0] d;
        for (int i = 0; i < NCH; i++) d[i*DW +: DW] = m_act[i];
        return d;
    endfunction

    task automatic model_edge();
        int a;
        int r;
        logic [DW-1:0] rd_next;
        r = int'(bus.rd_addr);
        rd_next = (r < NCH) ? m_act[r] : '0;
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                m_sh[i]  = RSTV;
                m_act[i] = RSTV;
            end
            m_pend = '0;
            m_err  = 0;
            m_cmt  = 0;
            m_upd  = 0;
            m_rd   = '0;
        end else begin
            if (bus.wr_valid && !m_cmt) begin
                a = int'(bus.wr_addr);
                if (a < NCH) begin
                    m_sh[a]   = bus.wr_data;
                    m_pend[a] = 1'b1;
                end else begin
                    m_err = 1;
                end
            end
            if (m_cmt) begin
                for (int i = 0; i < NCH; i++) if (m_pend[i]) m_act[i] = m_sh[i];
                m_pend = '0;
                m_upd  = 1;
                m_cmt  = 0;
            end else begin
                m_upd = 0;
                m_cmt = bus.commit;
            end
`ifdef REG_BANK_READBACK_EN
            m_rd = rd_next;
`else
            m_rd = '0;
`endif
        end
    endtask

    task automatic check_all();
        chk("wr_ready", 64'(bus.wr_ready), 64'(!m_cmt));
        chk("busy",     64'(bus.busy),     64'(m_cmt));
        chk("updated",  64'(bus.updated),  64'(m_upd));
        chk("pending",  64'(bus.pending),  64'(m_pend));
        chk("err",      64'(bus.err),      64'(m_err));
        chk("dout",     64'(bus.dout),     64'(model_dout()));
        chk("rd_data",  64'(bus.rd_data),  64'(m_rd));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic drive(input bit v, input int addr, input logic [DW-1:0] data, input bit cmt);
        bus.wr_valid = v;
        bus.wr_addr  = AW'(addr);
        bus.wr_data  = data;
        bus.commit   = cmt;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, '0, 0);
        bus.rd_addr = '0;
        #1;
        step();
        rst = 1'b0;
        step();
        chk("reset_dout", 64'(bus.dout), 64'h0);
        chk("reset_wr_ready", 64'(bus.wr_ready), 64'h1);

        // Two writes then a commit: DOUT only moves on the edge after the commit strobe
        drive(1, 0, 8'hA5, 0); step();
        drive(1, 2, 8'h3C, 0); step();
        chk("pending_101", 64'(bus.pending), 64'b101);
        drive(0, 0, '0, 1); step();
        chk("dout_before_commit_edge", 64'(bus.dout), 64'h0);
        drive(0, 0, '0, 0); step();
        chk("dout_after_commit", 64'(bus.dout), 64'h3C00A5);
        chk("updated_pulse", 64'(bus.updated), 64'h1);
        step();
        chk("updated_drops", 64'(bus.updated), 64'h0);

        // Write in the same cycle as commit is included in that commit
        drive(1, 1, 8'h11, 1); step();
        drive(0, 0, '0, 0); step();
        chk("same_cycle_write", 64'(bus.dout), 64'h3C11A5);

        // Write held through CMT is only accepted once back in IDLE
        drive(0, 0, '0, 1); step();
        drive(1, 1, 8'h22, 0); step();
        chk("stall_in_cmt_pending", 64'(bus.pending), 64'b000);
        step();
        drive(0, 0, '0, 0);
        chk("late_accept_pending", 64'(bus.pending), 64'b010);
        chk("late_accept_dout", 64'(bus.dout), 64'h3C11A5);
        step();

        // Out-of-range write flags ERR; commit while busy is dropped
        drive(1, 3, 8'hFF, 0); step();
        chk("err_set", 64'(bus.err), 64'h1);
        chk("err_dout", 64'(bus.dout), 64'h3C11A5);
        drive(0, 0, '0, 1); step();
        step();
        drive(0, 0, '0, 0); step();
        chk("no_second_update", 64'(bus.updated), 64'h0);
        chk("dout_ch1_22", 64'(bus.dout), 64'h3C22A5);

        // Reset mid-commit wins over the copy
        drive(1, 0, 8'h5A, 1); step();
        drive(0, 0, '0, 0);
        rst = 1'b1; step();
        rst = 1'b0;
        chk("rst_in_cmt_updated", 64'(bus.updated), 64'h0);
        chk("rst_in_cmt_dout", 64'(bus.dout), 64'h0);
        chk("rst_in_cmt_err", 64'(bus.err), 64'h0);
        step();

        // Randomized traffic; a stalled write keeps its address and data
        for (int n = 0; n < 600; n++) begin
            if (!(bus.wr_valid && m_cmt)) begin
                bus.wr_valid = ($urandom_range(0, 2) != 0);
                bus.wr_addr  = AW'($urandom_range(0, 3));
                bus.wr_data  = DW'($urandom);
            end
            bus.commit  = ($urandom_range(0, 5) == 0);
            bus.rd_addr = AW'($urandom_range(0, 3));
            rst         = ($urandom_range(0, 99) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
